cw_output: RTL
==============

# cw_output

Clockwise output stage of the cardinal router. Sits directly downstream of the clockwise input stage and the PE injection stage. For each virtual channel (even/odd) it arbitrates between their requests, holds the winning 64-bit flit in a one-entry VC buffer, and decrements the hop field. It then drives the flit onto the clockwise link in the opposite polarity phase, under the `cwso`/`cwro` handshake.

## Interface
Parameters:
- `DATA_WIDTH`, 64, flit width.
- `HOP_MSB`, 55, hop field MSB.
- `HOP_LSB`, 48, hop field LSB.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `polarity` input 1: router phase. 1 = odd VC internal / even VC on link; 0 = the reverse.
- `req_cw_even`, `req_cw_odd` input 1 each: requests from the clockwise input stage.
- `data_cw_even`, `data_cw_odd` input `DATA_WIDTH` each: flits, valid while the matching request is high.
- `req_pe_even`, `req_pe_odd` input 1 each: requests from the PE injection stage.
- `data_pe_even`, `data_pe_odd` input `DATA_WIDTH` each: flits, valid while the matching request is high.
- `grant_cw_even`, `grant_cw_odd`, `grant_pe_even`, `grant_pe_odd` output 1 each: combinational grants.
- `cwso` output 1: send strobe to the downstream router.
- `cwro` input 1: downstream ready.
- `cwdo` output `DATA_WIDTH`: link data.

## Operation
- Two one-entry buffers, `buf_even` and `buf_odd`, each with a full flag.
- **Arbitration, odd VC:** legal only when `polarity=1` and `buf_odd` is empty.
- **Arbitration, even VC:** legal only when `polarity=0` and `buf_even` is empty.
- In an illegal phase, or with the buffer full, all grants for that VC are 0 and requests stay pending.
- At most one grant per VC per cycle. Grants depend only on requests, `polarity`, full flags and priority pointers.
- **Load:** on the rising edge where a grant is high:
  - the buffer takes the granted data with the hop field replaced by hop−1;
  - hop = 0 saturates at 0;
  - all other bits are unchanged;
  - the full flag is set.
- **Link send:** at a rising edge with `polarity=0`, `buf_odd` full and `cwro=1`:
  - `cwso` goes to 1;
  - `cwdo` takes `buf_odd`;
  - `buf_odd` is cleared to empty.
- Even VC link send is symmetric, with `polarity=1` and `buf_even`.
- In all other cycles `cwso` is 0 and `cwdo` holds its last value.
- Load and send for the same VC never occur in the same cycle: they use opposite phases.
- `cwro=0` stalls the send. The buffer stays full, so that VC receives no grants until the send completes.

## Timing
- Grant path is combinational, same cycle as the request.
- The upstream stage samples the grant at the same edge the buffer loads.
- Latency is 2 edges from grant to `cwso`, with `cwro=1`:
  - edge 1 loads the buffer;
  - the next cycle is the link phase;
  - edge 2 registers `cwso`/`cwdo`.
- `cwso` is a one-cycle pulse per flit. Back-to-back flits on the same VC are spaced at least 2 cycles apart.
- **Reset values:**
  - `cwso` = 0;
  - `cwdo` = 0;
  - both full flags = 0;
  - both buffers = 0;
  - both priority pointers = CW;
  - all grants = 0, since buffers are empty and the pointers are defined.
- `rst` asserted mid-transfer discards buffered flits immediately and drops `cwso` without waiting for a clock.

## Configuration
- Macro `CW_OUTPUT_RR_ARB_EN`.
- **Defined:** per-VC round-robin arbitration.
  - When both requests are present, the pointer's source wins.
  - After any grant, the pointer moves to the other source.
- **Undefined:** fixed priority. CW always beats PE; pointers are absent.

## Test plan
- Reset release, then `polarity=1`, `req_cw_odd=1`, `data_cw_odd=64'h0003_0000_0000_00AA`, `cwro=1`. Required: `grant_cw_odd=1` that cycle; next edge `buf_odd` full; one edge later (`polarity=0`) `cwso=1` and `cwdo=64'h0002_0000_0000_00AA`.
- Even VC with `cwro=0` for 4 cycles, then `cwro=1` in a `polarity=1` cycle. Required: no `cwso` while stalled; a second `req_pe_even` receives no grant while stalled; `cwso` pulses once after the release.
- Simultaneous `req_cw_odd` and `req_pe_odd`, held for several odd phases, with `CW_OUTPUT_RR_ARB_EN` defined. Required: grants alternate CW, PE, CW. With the macro undefined: CW only.
- Hop field 0 on input. Required: output hop is still 0 and the other bits are unchanged.
- `req_cw_even` asserted while `polarity=1`. Required: no grant until `polarity=0`.
- `rst` pulsed between load and send. Required: `cwso` stays 0, `cwdo`=0, and a fresh request is granted immediately in its phase.

Source files
------------

// File: rtl/cw_output.sv
// cw_output: clockwise output stage. Per-VC arbitration between the CW input and PE injection
// stages, one-entry VC buffers with hop decrement, and phase-alternated link send under cwso/cwro.
// Define CW_OUTPUT_RR_ARB_EN for per-VC round-robin arbitration; default is fixed CW-over-PE priority.
module cw_output #(
    parameter int DATA_WIDTH = 64,
    parameter int HOP_MSB    = 55,
    parameter int HOP_LSB    = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  polarity,
    input  logic                  req_cw_even,
    input  logic                  req_cw_odd,
    input  logic [DATA_WIDTH-1:0] data_cw_even,
    input  logic [DATA_WIDTH-1:0] data_cw_odd,
    input  logic                  req_pe_even,
    input  logic                  req_pe_odd,
    input  logic [DATA_WIDTH-1:0] data_pe_even,
    input  logic [DATA_WIDTH-1:0] data_pe_odd,
    output logic                  grant_cw_even,
    output logic                  grant_cw_odd,
    output logic                  grant_pe_even,
    output logic                  grant_pe_odd,
    output logic                  cwso,
    input  logic                  cwro,
    output logic [DATA_WIDTH-1:0] cwdo
);

    localparam int HOP_W = HOP_MSB - HOP_LSB + 1;
    localparam logic [HOP_W-1:0] HOP_ONE = HOP_W'(1);

    logic [DATA_WIDTH-1:0] buf_even, buf_odd;
    logic                  full_even, full_odd;
    logic                  even_open, odd_open;

    // A VC accepts a new flit only in its internal phase and only when its buffer is empty.
    assign odd_open  = polarity & ~full_odd;
    assign even_open = ~polarity & ~full_even;

    // Hop field counts down and saturates at zero; every other bit passes through.
    function automatic logic [DATA_WIDTH-1:0] dec_hop(input logic [DATA_WIDTH-1:0] flit);
        logic [DATA_WIDTH-1:0] result;
        result = flit;
        if (flit[HOP_MSB:HOP_LSB] != '0)
            result[HOP_MSB:HOP_LSB] = flit[HOP_MSB:HOP_LSB] - HOP_ONE;
        return result;
    endfunction

`ifdef CW_OUTPUT_RR_ARB_EN
    typedef enum logic {SRC_CW = 1'b0, SRC_PE = 1'b1} src_e;

    src_e ptr_even, ptr_odd;

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        grant_cw_even = 1'b0;
        grant_pe_even = 1'b0;
        grant_cw_odd  = 1'b0;
        grant_pe_odd  = 1'b0;
        if (even_open) begin
            if (req_cw_even && req_pe_even) begin
                grant_cw_even = (ptr_even == SRC_CW);
                grant_pe_even = (ptr_even == SRC_PE);
            end else begin
                grant_cw_even = req_cw_even;
                grant_pe_even = req_pe_even;
            end
        end
        if (odd_open) begin
            if (req_cw_odd && req_pe_odd) begin
                grant_cw_odd = (ptr_odd == SRC_CW);
                grant_pe_odd = (ptr_odd == SRC_PE);
            end else begin
                grant_cw_odd = req_cw_odd;
                grant_pe_odd = req_pe_odd;
            end
        end
    end

    // After any grant the pointer hands priority to the other source.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_even <= SRC_CW;
            ptr_odd  <= SRC_CW;
        end else begin
            if (grant_cw_even)      ptr_even <= SRC_PE;
            else if (grant_pe_even) ptr_even <= SRC_CW;
            if (grant_cw_odd)       ptr_odd  <= SRC_PE;
            else if (grant_pe_odd)  ptr_odd  <= SRC_CW;
        end
    end
`else
    assign grant_cw_even = even_open & req_cw_even;
    assign grant_pe_even = even_open & req_pe_even & ~req_cw_even;
    assign grant_cw_odd  = odd_open & req_cw_odd;
    assign grant_pe_odd  = odd_open & req_pe_odd & ~req_cw_odd;
`endif

    // Load and send for one VC use opposite phases, so the if/else never hides an event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the flit buffers are reset too, so no stale flit can reach cwdo after reset.
            buf_even  <= '0;
            buf_odd   <= '0;
            full_even <= 1'b0;
            full_odd  <= 1'b0;
            cwso      <= 1'b0;
            cwdo      <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every register samples pre-edge values.
            cwso <= 1'b0;
            if (grant_cw_even || grant_pe_even) begin
                buf_even  <= dec_hop(grant_cw_even ? data_cw_even : data_pe_even);
                full_even <= 1'b1;
            end else if (polarity && full_even && cwro) begin
                cwso      <= 1'b1;
                cwdo      <= buf_even;
                full_even <= 1'b0;
            end
            if (grant_cw_odd || grant_pe_odd) begin
                buf_odd  <= dec_hop(grant_cw_odd ? data_cw_odd : data_pe_odd);
                full_odd <= 1'b1;
            end else if (!polarity && full_odd && cwro) begin
                cwso     <= 1'b1;
                cwdo     <= buf_odd;
                full_odd <= 1'b0;
            end
        end
    end

endmodule
